// File: rtl/freq_pkg.sv
// Shared types and level limits for the frequency step controller.
package freq_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      UP_HOLD   = 2'd1,
      DN_HOLD   = 2'd2,
      BOTH_LOCK = 2'd3
   } freq_state_e;

   localparam int LEVEL_W = 3;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
   localparam logic [LEVEL_W-1:0] LEVEL_MIN = 3'd0;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter; the debounced level
// follows the synchronized input only after DEBOUNCE_CYCLES equal samples.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk_i,
   input  logic reset,
   input  logic btn_i,
   output logic level_o
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count only while the synchronized sample disagrees with the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/freq_step_ctrl.sv
// Two-button frequency level controller: debounced press steps the level once,
// holding auto-repeats, pressing both locks out stepping until both release.
module freq_step_ctrl
   import freq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic               clk_i,
   input  logic               reset,
   input  logic               up_btn_i,
   input  logic               down_btn_i,
   output logic               up_step_o,
   output logic               down_step_o,
   output logic [LEVEL_W-1:0] level_o,
   output logic               at_max_o,
   output logic               at_min_o
);

   localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

   logic up_db;
   logic dn_db;
   logic up_db_q;
   logic dn_db_q;
   logic up_rise;
   logic dn_rise;

   freq_state_e       state_q;
   freq_state_e       state_d;
   logic [HOLD_W-1:0] hold_cnt_q;
   logic [HOLD_W-1:0] hold_cnt_d;
   logic              rep_q;
   logic              rep_d;
   logic              hold_fire;
   logic              up_req;
   logic              dn_req;

   logic [LEVEL_W-1:0] level_q;
   logic [LEVEL_W-1:0] level_d;
   logic               up_step_q;
   logic               up_step_d;
   logic               dn_step_q;
   logic               dn_step_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
      .clk_i   (clk_i),
      .reset   (reset),
      .btn_i   (up_btn_i),
      .level_o (up_db)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_db (
      .clk_i   (clk_i),
      .reset   (reset),
      .btn_i   (down_btn_i),
      .level_o (dn_db)
   );

   assign up_rise = up_db & ~up_db_q;
   assign dn_rise = dn_db & ~dn_db_q;

   // rep_q selects between the initial delay and the steady repeat period.
   assign hold_fire = rep_q ? (hold_cnt_q == PERIOD_LAST) : (hold_cnt_q == DELAY_LAST);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_d      = rep_q;
      up_req     = 1'b0;
      dn_req     = 1'b0;
      if (up_db && dn_db) begin
         state_d    = BOTH_LOCK;
         hold_cnt_d = '0;
         rep_d      = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               hold_cnt_d = '0;
               rep_d      = 1'b0;
               if (up_rise) begin
                  state_d = UP_HOLD;
                  up_req  = 1'b1;
               end else if (dn_rise) begin
                  state_d = DN_HOLD;
                  dn_req  = 1'b1;
               end
            end
            UP_HOLD, DN_HOLD: begin
               if ((state_q == UP_HOLD) ? !up_db : !dn_db) begin
                  state_d    = IDLE;
                  hold_cnt_d = '0;
                  rep_d      = 1'b0;
               end else if (hold_fire) begin
                  up_req     = (state_q == UP_HOLD);
                  dn_req     = (state_q == DN_HOLD);
                  hold_cnt_d = '0;
                  rep_d      = 1'b1;
               end else begin
                  hold_cnt_d = hold_cnt_q + HOLD_W'(1);
               end
            end
            BOTH_LOCK: begin
               if (!up_db && !dn_db) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Saturation: a request at the limit still advances the FSM but emits nothing.
   always_comb begin
      up_step_d = up_req && (level_q != LEVEL_MAX);
      dn_step_d = dn_req && (level_q != LEVEL_MIN);
      level_d   = level_q;
      if (up_step_d)      level_d = level_q + LEVEL_W'(1);
      else if (dn_step_d) level_d = level_q - LEVEL_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         rep_q      <= 1'b0;
         up_db_q    <= 1'b0;
         dn_db_q    <= 1'b0;
         level_q    <= LEVEL_MIN;
         up_step_q  <= 1'b0;
         dn_step_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         rep_q      <= rep_d;
         up_db_q    <= up_db;
         dn_db_q    <= dn_db;
         level_q    <= level_d;
         up_step_q  <= up_step_d;
         dn_step_q  <= dn_step_d;
      end
   end

   assign up_step_o   = up_step_q;
   assign down_step_o = dn_step_q;
   assign level_o     = level_q;
   assign at_max_o    = (level_q == LEVEL_MAX);
   assign at_min_o    = (level_q == LEVEL_MIN);

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Bench for freq_step_ctrl with short debounce/repeat timings.
module tb_freq_step_ctrl;

   localparam int D  = 4;
   localparam int RD = 8;
   localparam int RP = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       up_btn = 1'b0;
   logic       dn_btn = 1'b0;
   logic       up_step;
   logic       dn_step;
   logic [2:0] level;
   logic       at_max;
   logic       at_min;

   freq_step_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk_i       (clk),
      .reset       (reset),
      .up_btn_i    (up_btn),
      .down_btn_i  (dn_btn),
      .up_step_o   (up_step),
      .down_step_o (dn_step),
      .level_o     (level),
      .at_max_o    (at_max),
      .at_min_o    (at_min)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int n_up = 0;
   int n_dn = 0;
   bit chk_en = 1'b0;

   // Reference: per-button synchronized value, run length of disagreeing
   // samples, accepted level; press mode (0 none,1 up,2 down,3 lock) and
   // cycles since entry step.
   int m_s1[2];
   int m_s2[2];
   int m_db[2];
   int m_prev[2];
   int m_run[2];
   int m_mode;
   int m_age;
   int m_level;
   int m_up;
   int m_dn;

   function automatic void model_edge(bit rst, bit raw_up, bit raw_dn);
      int raw[2];
      int u, d, ur, dr, req_up, req_dn;
      raw[0] = raw_up;
      raw[1] = raw_dn;
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_prev[b] = 0; m_run[b] = 0;
         end
         m_mode = 0; m_age = 0; m_level = 0; m_up = 0; m_dn = 0;
         return;
      end
      u  = m_db[0];
      d  = m_db[1];
      ur = (u != 0 && m_prev[0] == 0) ? 1 : 0;
      dr = (d != 0 && m_prev[1] == 0) ? 1 : 0;
      req_up = 0;
      req_dn = 0;
      if (u != 0 && d != 0) begin
         m_mode = 3;
         m_age  = 0;
      end else if (m_mode == 0) begin
         if (ur != 0)      begin m_mode = 1; m_age = 0; req_up = 1; end
         else if (dr != 0) begin m_mode = 2; m_age = 0; req_dn = 1; end
      end else if (m_mode == 1 || m_mode == 2) begin
         if ((m_mode == 1 && u == 0) || (m_mode == 2 && d == 0)) begin
            m_mode = 0;
         end else begin
            m_age++;
            if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) begin
               if (m_mode == 1) req_up = 1; else req_dn = 1;
            end
         end
      end else if (u == 0 && d == 0) begin
         m_mode = 0;
      end
      m_up = (req_up != 0 && m_level < 7) ? 1 : 0;
      m_dn = (req_dn != 0 && m_level > 0) ? 1 : 0;
      m_level = m_level + m_up - m_dn;
      for (int b = 0; b < 2; b++) begin
         m_prev[b] = m_db[b];
         if (m_s2[b] != m_db[b]) begin
            m_run[b]++;
            if (m_run[b] == D) begin
               m_db[b]  = m_s2[b];
               m_run[b] = 0;
            end
         end else begin
            m_run[b] = 0;
         end
         m_s2[b] = m_s1[b];
         m_s1[b] = raw[b];
      end
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick();
      model_edge(reset, up_btn, dn_btn);
      @(posedge clk);
      #1;
      n_up += int'(up_step);
      n_dn += int'(dn_step);
      if (chk_en) begin
         check("model_level", int'(level), m_level);
         check("model_up_step", int'(up_step), m_up);
         check("model_down_step", int'(dn_step), m_dn);
         check("model_at_max", int'(at_max), (m_level == 7) ? 1 : 0);
         check("model_at_min", int'(at_min), (m_level == 0) ? 1 : 0);
         check("steps_exclusive", int'(up_step & dn_step), 0);
      end
   endtask

   typedef struct {
      bit up;
      bit dn;
      bit tog;
      int hold;
      int exp_level;
      int exp_ups;
      int exp_dns;
   } row_t;

   row_t rows[8];

   initial begin
      int first;

      rows[0] = '{up: 0, dn: 0, tog: 1, hold: 20, exp_level: 1, exp_ups: 0, exp_dns: 0};
      rows[1] = '{up: 0, dn: 1, tog: 0, hold: 5,  exp_level: 0, exp_ups: 0, exp_dns: 1};
      rows[2] = '{up: 0, dn: 1, tog: 0, hold: 5,  exp_level: 0, exp_ups: 0, exp_dns: 0};
      rows[3] = '{up: 1, dn: 0, tog: 0, hold: 30, exp_level: 7, exp_ups: 7, exp_dns: 0};
      rows[4] = '{up: 1, dn: 0, tog: 0, hold: 5,  exp_level: 7, exp_ups: 0, exp_dns: 0};
      rows[5] = '{up: 0, dn: 1, tog: 0, hold: 13, exp_level: 4, exp_ups: 0, exp_dns: 3};
      rows[6] = '{up: 1, dn: 0, tog: 0, hold: 9,  exp_level: 6, exp_ups: 2, exp_dns: 0};
      rows[7] = '{up: 1, dn: 1, tog: 0, hold: 10, exp_level: 6, exp_ups: 0, exp_dns: 0};

      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      tick();
      check("reset_level", int'(level), 0);
      check("reset_up_step", int'(up_step), 0);
      check("reset_down_step", int'(dn_step), 0);
      check("reset_at_min", int'(at_min), 1);
      check("reset_at_max", int'(at_max), 0);
      reset = 1'b0;
      repeat (3) tick();

      // Clean press held 5 cycles: pulse on the 7th edge.
      first = 0;
      n_up = 0;
      up_btn = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         if (c == 6) up_btn = 1'b0;
         tick();
         if (up_step && first == 0) first = c;
      end
      check("first_step_latency", first, D + 3);
      repeat (12) tick();
      check("single_press_pulses", n_up, 1);
      check("single_press_level", int'(level), 1);

      for (int r = 0; r < 8; r++) begin
         n_up = 0;
         n_dn = 0;
         for (int c = 0; c < rows[r].hold; c++) begin
            up_btn = rows[r].tog ? (((c / 2) % 2) == 0) : rows[r].up;
            dn_btn = rows[r].dn;
            tick();
         end
         up_btn = 1'b0;
         dn_btn = 1'b0;
         repeat (12) tick();
         check($sformatf("row%0d_level", r), int'(level), rows[r].exp_level);
         check($sformatf("row%0d_ups", r), n_up, rows[r].exp_ups);
         check($sformatf("row%0d_downs", r), n_dn, rows[r].exp_dns);
         check($sformatf("row%0d_at_max", r), int'(at_max), (rows[r].exp_level == 7) ? 1 : 0);
      end

      // Both held, then only down released: lockout persists until both release.
      n_up = 0;
      n_dn = 0;
      up_btn = 1'b1;
      dn_btn = 1'b1;
      repeat (12) tick();
      dn_btn = 1'b0;
      repeat (20) tick();
      check("lock_up_still_held", n_up + n_dn, 0);
      up_btn = 1'b0;
      repeat (12) tick();
      up_btn = 1'b1;
      repeat (5) tick();
      up_btn = 1'b0;
      repeat (12) tick();
      check("lock_repress_pulses", n_up, 1);
      check("lock_repress_level", int'(level), 7);

      // Reset in the middle of auto-repeat at level 5.
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      up_btn = 1'b1;
      repeat (30) tick();
      check("repeat_level_before_reset", int'(level), 5);
      reset = 1'b1;
      tick();
      check("reset_mid_hold_level", int'(level), 0);
      check("reset_mid_hold_pulse", int'(up_step), 0);
      tick();
      reset = 1'b0;
      first = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (up_step && first == 0) first = c;
      end
      check("post_reset_latency", first, D + 3);
      up_btn = 1'b0;
      repeat (12) tick();

      // Random sticky button activity with occasional reset.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(19) == 0) up_btn = ~up_btn;
         if ($urandom_range(19) == 0) dn_btn = ~dn_btn;
         reset = ($urandom_range(599) == 0);
         tick();
      end
      reset = 1'b0;
      up_btn = 1'b0;
      dn_btn = 1'b0;
      repeat (12) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
